// File: rtl/frontier_sysid_pkg.sv
// Shared constants for the frontier system-identification register bank.
package frontier_sysid_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned UPTIME_W = 64;

  // Word addresses of the register map
  localparam int unsigned REG_SYSID     = 0;
  localparam int unsigned REG_TIMESTAMP = 1;
  localparam int unsigned REG_CAPS      = 2;
  localparam int unsigned REG_SCRATCH   = 3;
  localparam int unsigned REG_UPTIME_LO = 4;
  localparam int unsigned REG_HI_SHADOW = 5;
  localparam int unsigned REG_SECONDS   = 6;
  localparam int unsigned REG_RESERVED  = 7;
  localparam int unsigned REG_FEAT_BASE = 8;

  // CAPS field positions
  localparam int unsigned CAPS_VERSION_LSB = 24;
  localparam int unsigned CAPS_NFEAT_LSB   = 16;

endpackage

// File: rtl/frontier_sysid_timebase.sv
// Free-running 64-bit uptime counter plus seconds counter driven by a cycle prescaler.
module frontier_sysid_timebase
  import frontier_sysid_pkg::*;
#(
  parameter int unsigned          CLOCK_HZ    = 50_000_000,
  parameter logic [UPTIME_W-1:0]  UPTIME_INIT = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear_i,
  output logic [UPTIME_W-1:0] uptime_o,
  output logic [DATA_W-1:0]   seconds_o
);

  localparam int unsigned PRE_W = $clog2(CLOCK_HZ);

  logic [UPTIME_W-1:0] uptime_q, uptime_d;
  logic [PRE_W-1:0]    prescaler_q, prescaler_d;
  logic [DATA_W-1:0]   seconds_q, seconds_d;

  // Next-state: count every cycle, roll seconds when the prescaler wraps, clear on request
  always_comb begin
    uptime_d    = uptime_q + UPTIME_W'(1);
    prescaler_d = prescaler_q + PRE_W'(1);
    seconds_d   = seconds_q;
    if (prescaler_q == PRE_W'(CLOCK_HZ - 1)) begin
      prescaler_d = '0;
      seconds_d   = seconds_q + DATA_W'(1);
    end
    if (clear_i) begin
      uptime_d    = '0;
      prescaler_d = '0;
      seconds_d   = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      uptime_q    <= UPTIME_INIT;
      prescaler_q <= '0;
      seconds_q   <= '0;
    end else begin
      uptime_q    <= uptime_d;
      prescaler_q <= prescaler_d;
      seconds_q   <= seconds_d;
    end
  end

  assign uptime_o  = uptime_q;
  assign seconds_o = seconds_q;

endmodule

// File: rtl/frontier_sysid_regs.sv
// Avalon-MM system-ID register bank: identity, caps, features, scratch, uptime and seconds.
module frontier_sysid_regs
  import frontier_sysid_pkg::*;
#(
  parameter logic [31:0]          SYSTEM_ID     = 32'h5005_0018,
  parameter logic [31:0]          TIMESTAMP     = 32'd12345,
  parameter logic [7:0]           VERSION       = 8'd2,
  parameter int unsigned          NUM_FEAT      = 4,
  parameter logic [((NUM_FEAT > 0) ? NUM_FEAT : 1)*32-1:0] FEATURE_WORDS = '0,
  parameter int unsigned          CLOCK_HZ      = 50_000_000,
  parameter int unsigned          ADDR_W        = 4,
  // Reset value of the uptime counter; 0 for normal builds
  parameter logic [UPTIME_W-1:0]  UPTIME_INIT   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  logic [31:0]         addr_ext;
  logic                hit_scratch, hit_uptime;
  logic [UPTIME_W-1:0] uptime;
  logic [DATA_W-1:0]   seconds;
  logic [DATA_W-1:0]   caps;
  logic [DATA_W-1:0]   rd_mux_c;

  logic [DATA_W-1:0]   readdata_q, readdata_d;
  logic                rdvalid_q, rdvalid_d;
  logic [DATA_W-1:0]   scratch_q, scratch_d;
  logic [DATA_W-1:0]   hi_shadow_q, hi_shadow_d;

  // Widen the address so feature-window bounds never truncate for small ADDR_W
  assign addr_ext    = 32'(address);
  assign hit_scratch = (addr_ext == 32'(REG_SCRATCH));
  assign hit_uptime  = (addr_ext == 32'(REG_UPTIME_LO));

  frontier_sysid_timebase #(
    .CLOCK_HZ    (CLOCK_HZ),
    .UPTIME_INIT (UPTIME_INIT)
  ) u_timebase (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (write && hit_uptime),
    .uptime_o  (uptime),
    .seconds_o (seconds)
  );

  // Capability word: version and feature count
  always_comb begin
    caps = '0;
    caps[CAPS_VERSION_LSB +: 8] = VERSION;
    caps[CAPS_NFEAT_LSB +: 8]   = 8'(NUM_FEAT);
  end

  // Read decode from current (pre-write) register values
  always_comb begin
    rd_mux_c = '0;
    case (addr_ext)
      32'(REG_SYSID):     rd_mux_c = SYSTEM_ID;
      32'(REG_TIMESTAMP): rd_mux_c = TIMESTAMP;
      32'(REG_CAPS):      rd_mux_c = caps;
      32'(REG_SCRATCH):   rd_mux_c = scratch_q;
      32'(REG_UPTIME_LO): rd_mux_c = uptime[31:0];
      32'(REG_HI_SHADOW): rd_mux_c = hi_shadow_q;
      32'(REG_SECONDS):   rd_mux_c = seconds;
      default:            rd_mux_c = '0;
    endcase
    for (int unsigned k = 0; k < NUM_FEAT; k++) begin
      if (addr_ext == 32'(REG_FEAT_BASE + k)) rd_mux_c = FEATURE_WORDS[k*32 +: 32];
    end
  end

  // Next-state for read pipeline, scratch and coherent high-word shadow
  always_comb begin
    readdata_d  = readdata_q;
    rdvalid_d   = read;
    scratch_d   = scratch_q;
    hi_shadow_d = hi_shadow_q;
    if (read) readdata_d = rd_mux_c;
    if (read && hit_uptime) hi_shadow_d = uptime[63:32];
    if (write && hit_scratch) scratch_d = writedata;
  end

  // Register stage with synchronous reset; a read in the reset cycle is dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata_q  <= '0;
      rdvalid_q   <= 1'b0;
      scratch_q   <= '0;
      hi_shadow_q <= '0;
    end else begin
      readdata_q  <= readdata_d;
      rdvalid_q   <= rdvalid_d;
      scratch_q   <= scratch_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdvalid_q;

endmodule
